// File: rtl/sd_pkg.sv
// Shared types and constants for the host-side SD sector buffer.
// The FSM state encoding lives here so the buffer and its RAM agree on sizes.
package sd_pkg;

   localparam int SD_SECTOR_BYTES = 512;
   localparam int SD_BUF_AW       = $clog2(SD_SECTOR_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_PRIME = 3'd1,
      ST_REQ_RD   = 3'd2,
      ST_REQ_WR   = 3'd3,
      ST_RD_DATA  = 3'd4,
      ST_WR_DATA  = 3'd5,
      ST_DONE     = 3'd6
   } sd_buf_state_t;

   // States in which a transfer is in flight and may be aborted.
   function automatic logic sd_abortable(input sd_buf_state_t st);
      logic act;
      case (st)
         ST_IDLE: act = 1'b0;
         ST_DONE: act = 1'b0;
         default: act = 1'b1;
      endcase
      return act;
   endfunction

endpackage

// File: rtl/sd_block_buffer_ram.sv
// Single-port sector RAM with registered read data (one-cycle latency).
// Read returns the old contents on a same-address write.
module sd_buf_ram
   import sd_pkg::*;
#(
   parameter int DEPTH = SD_SECTOR_BYTES,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem_r [DEPTH];

   // Synchronous write and registered read on the shared port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
      rdata <= mem_r[addr];
   end

endmodule

// File: rtl/sd_block_buffer.sv
// Host-side sector buffer: owns one sector RAM and sequences single-sector
// reads/writes over the io_* handshake of the SD card subsystem.
module sd_block_buffer
   import sd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2_000_000,
   parameter int SECTOR_BYTES   = SD_SECTOR_BYTES,
   localparam int AW            = $clog2(SECTOR_BYTES)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [31:0]   cmd_lba,
   output logic          busy,
   output logic          done,
   output logic          error,
   input  logic [AW-1:0] buf_addr,
   input  logic          buf_we,
   input  logic [7:0]    buf_wdata,
   output logic [7:0]    buf_rdata,
   input  logic          disk_mounted,
   input  logic          event_error,
   output logic [31:0]   io_lba,
   output logic          io_rd,
   output logic          io_wr,
   input  logic          io_ack,
   input  logic [7:0]    io_din,
   input  logic          io_din_tvalid,
   output logic [7:0]    io_dout,
   input  logic          io_dout_tvalid
);

   localparam int CW = AW + 1;
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(SECTOR_BYTES - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(SECTOR_BYTES);
   localparam logic [WW-1:0] WD_LOAD  = WW'(TIMEOUT_CYCLES);

   sd_buf_state_t state_r, state_s, case_next_s;

   logic          cmd_ready_r, busy_r, done_r, error_r;
   logic          io_rd_r, io_wr_r;
   logic [31:0]   io_lba_r;
   logic [7:0]    io_dout_r, next_r;
   logic          prime_r, fetch_r, fetch_zero_r;
   logic [CW-1:0] cnt_r, cnt_plus2_s;
   logic [WW-1:0] wd_r;

   logic          accept_s, rd_beat_s, wr_beat_s, beat_s, last_beat_s;
   logic          ack_s, reload_s, expire_s, abort_s, reject_s;
   logic [AW-1:0] fsm_addr_s, ram_addr_s;
   logic          fsm_we_s, ram_we_s;
   logic [7:0]    ram_wdata_s, ram_rdata_s;

   assign accept_s    = cmd_valid & cmd_ready_r;
   assign reject_s    = accept_s & ~disk_mounted;
   assign rd_beat_s   = (state_r == ST_RD_DATA) & io_din_tvalid;
   assign wr_beat_s   = (state_r == ST_WR_DATA) & io_dout_tvalid;
   assign beat_s      = rd_beat_s | wr_beat_s;
   assign last_beat_s = beat_s & (cnt_r == CNT_LAST);
   assign ack_s       = io_ack & ((state_r == ST_REQ_RD) | (state_r == ST_REQ_WR));
   assign reload_s    = accept_s | ack_s | beat_s;
   assign expire_s    = sd_abortable(state_r) & ~reload_s & (wd_r <= WW'(1));
   assign abort_s     = sd_abortable(state_r) & (event_error | expire_s);
   assign cnt_plus2_s = cnt_r + CW'(2);

   // Next-state decode; an abort overrides every other transition.
   always_comb begin
      case_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && disk_mounted) begin
               case_next_s = cmd_write ? ST_WR_PRIME : ST_REQ_RD;
            end else begin
               case_next_s = ST_IDLE;
            end
         end
         ST_WR_PRIME: case_next_s = prime_r ? ST_REQ_WR : ST_WR_PRIME;
         ST_REQ_RD:   case_next_s = io_ack ? ST_RD_DATA : ST_REQ_RD;
         ST_REQ_WR:   case_next_s = io_ack ? ST_WR_DATA : ST_REQ_WR;
         ST_RD_DATA:  case_next_s = last_beat_s ? ST_DONE : ST_RD_DATA;
         ST_WR_DATA:  case_next_s = last_beat_s ? ST_DONE : ST_WR_DATA;
         ST_DONE:     case_next_s = ST_IDLE;
         default:     case_next_s = ST_IDLE;
      endcase
      state_s = abort_s ? ST_IDLE : case_next_s;
   end

   // RAM port mux: the host owns the port while idle, the FSM while busy.
   always_comb begin
      fsm_addr_s = AW'(0);
      fsm_we_s   = 1'b0;
      case (state_r)
         ST_WR_PRIME: fsm_addr_s = prime_r ? AW'(1) : AW'(0);
         ST_RD_DATA: begin
            fsm_addr_s = cnt_r[AW-1:0];
            fsm_we_s   = rd_beat_s;
         end
         ST_WR_DATA:  fsm_addr_s = cnt_plus2_s[AW-1:0];
         default:     fsm_addr_s = AW'(0);
      endcase
      if (busy_r) begin
         ram_addr_s  = fsm_addr_s;
         ram_we_s    = fsm_we_s;
         ram_wdata_s = io_din;
      end else begin
         ram_addr_s  = buf_addr;
         ram_we_s    = buf_we;
         ram_wdata_s = buf_wdata;
      end
   end

   sd_buf_ram #(
      .DEPTH (SECTOR_BYTES),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .addr  (ram_addr_s),
      .we    (ram_we_s),
      .wdata (ram_wdata_s),
      .rdata (ram_rdata_s)
   );

   // State register and handshake/status outputs, all derived from next state.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r     <= ST_IDLE;
         cmd_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
         io_rd_r     <= 1'b0;
         io_wr_r     <= 1'b0;
         io_lba_r    <= 32'h0000_0000;
      end else begin
         state_r     <= state_s;
         cmd_ready_r <= (state_s == ST_IDLE);
         busy_r      <= sd_abortable(state_s);
         done_r      <= (state_s == ST_DONE);
         error_r     <= abort_s | reject_s;
         io_rd_r     <= (state_s == ST_REQ_RD);
         io_wr_r     <= (state_s == ST_REQ_WR);
         if (accept_s) begin
            io_lba_r <= cmd_lba;
         end
      end
   end

   // Beat counter, priming phase and no-progress watchdog.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_r   <= CW'(0);
         prime_r <= 1'b0;
         wd_r    <= WW'(0);
      end else begin
         if (accept_s) begin
            cnt_r <= CW'(0);
         end else if (beat_s) begin
            cnt_r <= cnt_r + CW'(1);
         end
         prime_r <= (state_r == ST_WR_PRIME) ? ~prime_r : 1'b0;
         if (reload_s) begin
            wd_r <= WD_LOAD;
         end else if (sd_abortable(state_r) && (wd_r != WW'(0))) begin
            wd_r <= wd_r - WW'(1);
         end
      end
   end

   // Write pipeline: io_dout holds the current byte, next_r the one after it.
   // A fetch issued on a beat lands in next_r a cycle later; past the end it reads as zero.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         io_dout_r    <= 8'h00;
         next_r       <= 8'h00;
         fetch_r      <= 1'b0;
         fetch_zero_r <= 1'b0;
      end else begin
         if ((state_r == ST_WR_PRIME) && prime_r) begin
            io_dout_r <= ram_rdata_s;
         end else if (wr_beat_s) begin
            io_dout_r <= next_r;
         end
         fetch_r      <= ((state_r == ST_WR_PRIME) & prime_r) | wr_beat_s;
         fetch_zero_r <= wr_beat_s & (cnt_plus2_s >= CNT_END);
         if (fetch_r) begin
            next_r <= fetch_zero_r ? 8'h00 : ram_rdata_s;
         end
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign error     = error_r;
   assign io_lba    = io_lba_r;
   assign io_rd     = io_rd_r;
   assign io_wr     = io_wr_r;
   assign io_dout   = io_dout_r;
   assign buf_rdata = ram_rdata_s;

endmodule

// File: tb/tb_sd_block_buffer.sv
// Directed bench for sd_block_buffer with a bench-side io_* responder and a
// byte scoreboard for streamed and read-back data.
module tb_sd_block_buffer;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_lba;
   logic        busy, done, error;
   logic [8:0]  buf_addr;
   logic        buf_we;
   logic [7:0]  buf_wdata, buf_rdata;
   logic        disk_mounted, event_error;
   logic [31:0] io_lba;
   logic        io_rd, io_wr, io_ack;
   logic [7:0]  io_din, io_dout;
   logic        io_din_tvalid, io_dout_tvalid;

   int          tests = 0;
   int          fails = 0;
   logic [7:0]  sb[$];

   always #5 clk = ~clk;

   sd_block_buffer #(.TIMEOUT_CYCLES(1000)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_lba(cmd_lba),
      .busy(busy), .done(done), .error(error),
      .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
      .disk_mounted(disk_mounted), .event_error(event_error),
      .io_lba(io_lba), .io_rd(io_rd), .io_wr(io_wr), .io_ack(io_ack),
      .io_din(io_din), .io_din_tvalid(io_din_tvalid),
      .io_dout(io_dout), .io_dout_tvalid(io_dout_tvalid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_buf(input logic [7:0] key);
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         buf_addr  = 9'(i);
         buf_we    = 1'b1;
         buf_wdata = 8'(i) ^ key;
      end
      @(negedge clk);
      buf_we = 1'b0;
   endtask

   task automatic host_read(input logic [8:0] a, output logic [7:0] d);
      @(negedge clk);
      buf_addr = a;
      @(posedge clk);
      #1 d = buf_rdata;
   endtask

   task automatic send_cmd(input logic w, input logic [31:0] lba);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_lba   = lba;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic grant_req(input string tag, input logic w);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if ((w ? io_wr : io_rd) === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, " request"}, 32'(seen), 32'd1);
      repeat (2) @(negedge clk);
      chk({tag, " request held"}, 32'(w ? io_wr : io_rd), 32'd1);
      io_ack = 1'b1;
      @(posedge clk);
      #1 chk({tag, " request drop on ack"}, 32'(w ? io_wr : io_rd), 32'd0);
      @(negedge clk);
      io_ack = 1'b0;
   endtask

   task automatic write_beats(input string tag, input int n);
      logic [7:0] exp;
      for (int b = 0; b < n; b++) begin
         @(negedge clk);
         exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
         chk(tag, 32'(io_dout), 32'(exp));
         io_dout_tvalid = 1'b1;
         @(negedge clk);
         io_dout_tvalid = 1'b0;
      end
   endtask

   task automatic read_beats(input int first, input int n, input bit alt);
      for (int i = first; i < first + n; i++) begin
         @(negedge clk);
         io_din        = alt ? (8'(i) ^ 8'hFF) : 8'(3 * i);
         io_din_tvalid = 1'b1;
         @(negedge clk);
         io_din_tvalid = 1'b0;
      end
   endtask

   task automatic wait_done(input string tag);
      logic d, e;
      for (int k = 0; k < 20; k++) begin
         if (done === 1'b1 || error === 1'b1) break;
         @(negedge clk);
      end
      d = done;
      e = error;
      chk({tag, " done"}, 32'(d), 32'd1);
      chk({tag, " no error"}, 32'(e), 32'd0);
      chk({tag, " busy clear"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [7:0] d;
      logic       wr_prev;
      int         k;

      resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_lba = 32'h0;
      buf_addr = 9'h0; buf_we = 1'b0; buf_wdata = 8'h0;
      disk_mounted = 1'b1; event_error = 1'b0;
      io_ack = 1'b0; io_din = 8'h0; io_din_tvalid = 1'b0; io_dout_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset error", 32'(error), 32'd0);
      chk("reset io_rd", 32'(io_rd), 32'd0);
      chk("reset io_wr", 32'(io_wr), 32'd0);
      chk("reset io_lba", io_lba, 32'h0);
      chk("reset io_dout", 32'(io_dout), 32'h0);
      resetn = 1'b1;

      // Sector write of i ^ 0x5A to LBA 0x10
      load_buf(8'h5A);
      host_read(9'd3, d);
      chk("host readback", 32'(d), 32'h59);
      for (int i = 0; i < 512; i++) sb.push_back(8'(i) ^ 8'h5A);
      send_cmd(1'b1, 32'h10);
      chk("write io_lba", io_lba, 32'h10);
      chk("write busy", 32'(busy), 32'd1);
      chk("write cmd_ready low", 32'(cmd_ready), 32'd0);
      grant_req("write", 1'b1);
      write_beats("write byte", 512);
      wait_done("write");
      @(posedge clk);
      #1 chk("write done one cycle", 32'(done), 32'd0);

      // Sector read of (3*i)%256 from LBA 0x20
      send_cmd(1'b0, 32'h20);
      chk("read io_lba", io_lba, 32'h20);
      grant_req("read", 1'b0);
      read_beats(0, 512, 1'b0);
      wait_done("read");
      sb.push_back(8'h00); sb.push_back(8'h03); sb.push_back(8'hFD);
      host_read(9'd0, d);   chk("read buf[0]", 32'(d), 32'(sb.pop_front()));
      host_read(9'd1, d);   chk("read buf[1]", 32'(d), 32'(sb.pop_front()));
      host_read(9'd511, d); chk("read buf[511]", 32'(d), 32'(sb.pop_front()));

      // Not mounted
      disk_mounted = 1'b0;
      send_cmd(1'b0, 32'h50);
      chk("unmounted error", 32'(error), 32'd1);
      chk("unmounted cmd_ready", 32'(cmd_ready), 32'd1);
      chk("unmounted io_rd", 32'(io_rd), 32'd0);
      @(posedge clk);
      #1 chk("unmounted error pulse", 32'(error), 32'd0);
      chk("unmounted io_rd later", 32'(io_rd), 32'd0);
      disk_mounted = 1'b1;

      // event_error after 100 beats, then a clean read
      send_cmd(1'b0, 32'h21);
      grant_req("evt read", 1'b0);
      read_beats(0, 100, 1'b0);
      @(negedge clk);
      event_error = 1'b1;
      @(posedge clk);
      #1 chk("evt error", 32'(error), 32'd1);
      chk("evt no done", 32'(done), 32'd0);
      chk("evt io_rd", 32'(io_rd), 32'd0);
      chk("evt busy", 32'(busy), 32'd0);
      @(negedge clk);
      event_error = 1'b0;
      send_cmd(1'b0, 32'h22);
      grant_req("post evt read", 1'b0);
      read_beats(0, 512, 1'b1);
      wait_done("post evt read");
      host_read(9'd5, d);
      chk("post evt buf[5]", 32'(d), 32'hFA);

      // event_error coincident with the final beat
      send_cmd(1'b0, 32'h23);
      grant_req("last read", 1'b0);
      read_beats(0, 511, 1'b0);
      @(negedge clk);
      io_din = 8'hAA; io_din_tvalid = 1'b1; event_error = 1'b1;
      @(posedge clk);
      #1 chk("last beat error wins", 32'(error), 32'd1);
      chk("last beat no done", 32'(done), 32'd0);
      @(negedge clk);
      io_din_tvalid = 1'b0; event_error = 1'b0;
      @(posedge clk);
      #1 chk("last beat no late done", 32'(done), 32'd0);

      // Watchdog: no ack for a write
      send_cmd(1'b1, 32'h40);
      k = 0;
      wr_prev = 1'b0;
      while (k < 1100) begin
         @(posedge clk);
         #1 k++;
         if (error === 1'b1) break;
         wr_prev = io_wr;
      end
      chk("timeout cycle", 32'(k), 32'd1000);
      chk("timeout io_wr held", 32'(wr_prev), 32'd1);
      chk("timeout io_wr drop", 32'(io_wr), 32'd0);

      // Reset mid-write at beat 200, then a fresh write from byte 0
      load_buf(8'hC3);
      for (int i = 0; i < 512; i++) sb.push_back(8'(i) ^ 8'hC3);
      send_cmd(1'b1, 32'h30);
      grant_req("rst write", 1'b1);
      write_beats("rst write byte", 200);
      sb.delete();
      @(negedge clk);
      resetn = 1'b0;
      @(posedge clk);
      #1 chk("midreset io_wr", 32'(io_wr), 32'd0);
      chk("midreset busy", 32'(busy), 32'd0);
      chk("midreset io_dout", 32'(io_dout), 32'h0);
      chk("midreset cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 512; i++) sb.push_back(8'(i) ^ 8'hC3);
      send_cmd(1'b1, 32'h31);
      grant_req("fresh write", 1'b1);
      write_beats("fresh write byte", 512);
      wait_done("fresh write");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
